// File: rtl/binary_add_seq_if.sv
// binary_add_seq_if - operand/result handshake bundle for binary_add_seq.
//
// Signals (named from the adder's point of view):
//   in_valid  / in_ready   operand handshake (producer -> adder)
//   a, b                   operands, WIDTH bits
//   cin                    carry-in, used only in add mode
//   sub                    0: a+b+cin, 1: a-b
//   out_valid / out_ready  result handshake (adder -> consumer)
//   s                      sum/difference modulo 2^WIDTH
//   cout                   carry out of the MSB (subtract: 1 = no borrow)
//   ovf                    two's-complement signed overflow
//
// Modports:
//   master - the producer/consumer side driving operands and out_ready
//   slave  - the adder itself
interface binary_add_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/binary_add_seq.sv
// binary_add_seq - multi-cycle WIDTH-bit adder/subtractor.
//
// Adds CHUNK bits per clock through a narrow carry chain, so a result takes
// N = WIDTH/CHUNK cycles after the operands are accepted. Subtraction is
// a + ~b + 1. The result is wrapped modulo 2^WIDTH; overflow is only flagged.
//
// Ports:
//   clk   - single clock, all state on the rising edge
//   rst   - synchronous, active-high reset; discards any in-flight operation
//   bus   - binary_add_seq_if.slave: operand handshake (in_valid/in_ready,
//           a, b, cin, sub) and result handshake (out_valid/out_ready,
//           s, cout, ovf). s/cout/ovf are registers, valid while out_valid=1.
module binary_add_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst,
    binary_add_seq_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("binary_add_seq: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // b already inverted in subtract mode
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      sh_s;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   sum_s;
    logic             last_s;

    // Pick the chunk addressed by idx and add it through the narrow carry chain.
    always_comb begin
        sh_s      = 32'(idx_q) * 32'(CHUNK);
        a_chunk_s = CHUNK'(a_q >> sh_s);
        b_chunk_s = CHUNK'(b_q >> sh_s);
        sum_s     = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_q};
        last_s    = (idx_q == IDX_W'(N - 1));
    end

    // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    // The +1 of the two's-complement negate rides in as carry-in.
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                s_d     = (s_q & ~(CHUNK_MASK << sh_s))
                        | (WIDTH'(sum_s[CHUNK-1:0]) << sh_s);
                carry_d = sum_s[CHUNK];
                if (last_s) begin
                    cout_d  = sum_s[CHUNK];
                    // sum_s[CHUNK-1] is the new result MSB on the top chunk.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                           && (sum_s[CHUNK-1] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_binary_add_seq.sv
`timescale 1ns/1ps
module tb_binary_add_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    binary_add_seq_if #(.WIDTH(16)) bus16 ();
    binary_add_seq_if #(.WIDTH(4))  bus4  ();
    binary_add_seq_if #(.WIDTH(8))  bus8  ();

    binary_add_seq #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    binary_add_seq #(.WIDTH(4),  .CHUNK(4)) dut4  (.clk(clk), .rst(rst), .bus(bus4));
    binary_add_seq #(.WIDTH(8),  .CHUNK(2)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    // Shared stimulus, steered to one DUT: 0 = 16/4, 1 = 4/4, 2 = 8/2.
    int          sel;
    logic        t_in_valid, t_out_ready, t_cin, t_sub;
    logic [15:0] t_a, t_b;

    assign bus16.in_valid  = t_in_valid  && (sel == 0);
    assign bus4.in_valid   = t_in_valid  && (sel == 1);
    assign bus8.in_valid   = t_in_valid  && (sel == 2);
    assign bus16.out_ready = t_out_ready && (sel == 0);
    assign bus4.out_ready  = t_out_ready && (sel == 1);
    assign bus8.out_ready  = t_out_ready && (sel == 2);
    assign bus16.a = t_a;       assign bus16.b = t_b;
    assign bus4.a  = t_a[3:0];  assign bus4.b  = t_b[3:0];
    assign bus8.a  = t_a[7:0];  assign bus8.b  = t_b[7:0];
    assign bus16.cin = t_cin;   assign bus16.sub = t_sub;
    assign bus4.cin  = t_cin;   assign bus4.sub  = t_sub;
    assign bus8.cin  = t_cin;   assign bus8.sub  = t_sub;

    logic        o_in_ready, o_out_valid, o_cout, o_ovf;
    logic [15:0] o_s;
    always_comb begin
        case (sel)
            1: begin
                o_in_ready = bus4.in_ready; o_out_valid = bus4.out_valid;
                o_s = {12'h000, bus4.s}; o_cout = bus4.cout; o_ovf = bus4.ovf;
            end
            2: begin
                o_in_ready = bus8.in_ready; o_out_valid = bus8.out_valid;
                o_s = {8'h00, bus8.s}; o_cout = bus8.cout; o_ovf = bus8.ovf;
            end
            default: begin
                o_in_ready = bus16.in_ready; o_out_valid = bus16.out_valid;
                o_s = bus16.s; o_cout = bus16.cout; o_ovf = bus16.ovf;
            end
        endcase
    end

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    // Issue one operation (caller sits just after a rising edge, DUT idle) and
    // wait for out_valid. Operands are scrambled right after acceptance. lat=-1
    // on timeout. The result is left pending in DONE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          output logic [15:0] s, output logic co,
                          output logic ov, output int lat);
        t_out_ready = 1'b0;
        t_a = a; t_b = b; t_cin = cin; t_sub = sub; t_in_valid = 1'b1;
        @(posedge clk); #1;
        t_in_valid = 1'b0;
        t_a = ~a; t_b = ~b; t_cin = ~cin; t_sub = ~sub;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (o_out_valid) begin
                lat = i;
                break;
            end
        end
        s = o_s; co = o_cout; ov = o_ovf;
    endtask

    task automatic release_out();
        t_out_ready = 1'b1;
        @(posedge clk); #1;
        t_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        sel = 0;
        n_vec++;
        if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_s !== 16'h0000
            || o_cout !== 1'b0 || o_ovf !== 1'b0 || bus4.out_valid !== 1'b0
            || bus8.out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state: rdy=%b vld=%b s=%h co=%b ov=%b vld4=%b vld8=%b, want 1 0 0000 0 0 0 0",
                     o_in_ready, o_out_valid, o_s, o_cout, o_ovf, bus4.out_valid, bus8.out_valid);
        end
        // Abort an operation mid-CALC; in_valid is held high during reset.
        t_a = 16'h1234; t_b = 16'h1111; t_cin = 1'b0; t_sub = 1'b0; t_in_valid = 1'b1;
        @(posedge clk); #1;          // T0
        t_in_valid = 1'b0;
        @(posedge clk); #1;          // T1
        rst = 1'b1; t_in_valid = 1'b1;
        @(posedge clk); #1;          // T2, reset sampled
        rst = 1'b0; t_in_valid = 1'b0;
        n_vec++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_s !== 16'h0000
            || o_cout !== 1'b0 || o_ovf !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_midcalc: vld=%b rdy=%b s=%h co=%b ov=%b, want 0 1 0000 0 0",
                     o_out_valid, o_in_ready, o_s, o_cout, o_ovf);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            seen = seen | o_out_valid;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_no_output: out_valid seen=%b, want 0", seen);
        end
    endtask

    task automatic test_arith();
        vec_t        vt [12];
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        sel = 0;
        vt[0]  = {16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[1]  = {16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vt[2]  = {16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[3]  = {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[4]  = {16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vt[5]  = {16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[6]  = {16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[7]  = {16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[8]  = {16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[9]  = {16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[10] = {16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[11] = {16'h0000, 16'h8000, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1};
        for (int k = 0; k < 12; k++) begin
            run_op(vt[k].a, vt[k].b, vt[k].cin, vt[k].sub, s, co, ov, lat);
            n_vec++;
            if (lat !== 4 || s !== vt[k].s || co !== vt[k].co || ov !== vt[k].ov) begin
                n_miss++;
                $display("FAIL arith[%0d]: lat=%0d s=%h co=%b ov=%b, want lat=4 s=%h co=%b ov=%b",
                         k, lat, s, co, ov, vt[k].s, vt[k].co, vt[k].ov);
            end
            release_out();
            n_vec++;
            if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL arith_release[%0d]: rdy=%b vld=%b, want 1 0", k, o_in_ready, o_out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        sel = 0;
        run_op(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, s, co, ov, lat);   // 0xFFFF, co 0, ov 1
        n_vec++;
        if (lat !== 4 || s !== 16'hFFFF || co !== 1'b0 || ov !== 1'b1) begin
            n_miss++;
            $display("FAIL bp_first: lat=%0d s=%h co=%b ov=%b, want 4 ffff 0 1", lat, s, co, ov);
        end
        for (int i = 0; i < 5; i++) begin
            t_in_valid = 1'b1; t_a = 16'h0100 + 16'(i); t_b = 16'h0001; t_sub = 1'b1;
            @(posedge clk); #1;
            n_vec++;
            if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || o_s !== 16'hFFFF
                || o_cout !== 1'b0 || o_ovf !== 1'b1) begin
                n_miss++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b s=%h co=%b ov=%b, want 1 0 ffff 0 1",
                         i, o_out_valid, o_in_ready, o_s, o_cout, o_ovf);
            end
        end
        t_in_valid = 1'b0;
        release_out();
        n_vec++;
        if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL bp_release: rdy=%b vld=%b, want 1 0", o_in_ready, o_out_valid);
        end
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0, s, co, ov, lat);
        n_vec++;
        if (lat !== 4 || s !== 16'h0003 || co !== 1'b0 || ov !== 1'b0) begin
            n_miss++;
            $display("FAIL bp_next: lat=%0d s=%h co=%b ov=%b, want 4 0003 0 0", lat, s, co, ov);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        sel = 0;
        t_out_ready = 1'b1;
        t_a = 16'h1111; t_b = 16'h2222; t_cin = 1'b1; t_sub = 1'b0; t_in_valid = 1'b1;
        @(posedge clk); #1;          // first acceptance
        t_a = 16'h0100; t_b = 16'h0001; t_cin = 1'b0; t_sub = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (o_out_valid) begin lat = i; break; end
        end
        n_vec++;
        if (lat !== 4 || o_s !== 16'h3334 || o_cout !== 1'b0 || o_ovf !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_first: lat=%0d s=%h co=%b ov=%b, want 4 3334 0 0", lat, o_s, o_cout, o_ovf);
        end
        @(posedge clk); #1;          // DONE lasts one cycle with out_ready high
        n_vec++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL b2b_done_one_cycle: vld=%b rdy=%b, want 0 1", o_out_valid, o_in_ready);
        end
        @(posedge clk); #1;          // second acceptance
        t_in_valid = 1'b0;
        n_vec++;
        if (o_in_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_accept: rdy=%b, want 0", o_in_ready);
        end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (o_out_valid) begin lat = i; break; end
        end
        n_vec++;
        if (lat !== 4 || o_s !== 16'h00FF || o_cout !== 1'b1 || o_ovf !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_second: lat=%0d s=%h co=%b ov=%b, want 4 00ff 1 0", lat, o_s, o_cout, o_ovf);
        end
        @(posedge clk); #1;
        t_out_ready = 1'b0;
        n_vec++;
        if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_idle: rdy=%b vld=%b, want 1 0", o_in_ready, o_out_valid);
        end
    endtask

    // Exhaustive (which=1, 4-bit) or random (which=2, 8-bit) sweep against an
    // integer reference: unsigned sum/difference, unsigned carry, signed range.
    task automatic test_config_sweep(input int which, input int w, input int n_lat);
        int          total, ai, bi, ci, si, mask, half, sa, sb, res, es;
        logic        ec, eo;
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        sel   = which;
        mask  = (1 << w) - 1;
        half  = 1 << (w - 1);
        total = (which == 1) ? 512 : 1000;
        for (int k = 0; k < total; k++) begin
            if (which == 1) begin
                ai = k & 15; bi = (k >> 4) & 15; si = (k >> 8) & 1;
                ci = (ai ^ (bi >> 1)) & 1;
            end else begin
                ai = int'($urandom_range(255)); bi = int'($urandom_range(255));
                si = int'($urandom_range(1));   ci = int'($urandom_range(1));
            end
            sa = (ai >= half) ? ai - (1 << w) : ai;
            sb = (bi >= half) ? bi - (1 << w) : bi;
            if (si == 1) begin
                es  = (ai - bi) & mask;
                ec  = (ai >= bi);
                res = sa - sb;
            end else begin
                es  = (ai + bi + ci) & mask;
                ec  = ((ai + bi + ci) > mask);
                res = sa + sb + ci;
            end
            eo = (res >= half) || (res < -half);
            run_op(16'(ai), 16'(bi), ci[0], si[0], s, co, ov, lat);
            n_vec++;
            if (lat !== n_lat || s !== 16'(es) || co !== ec || ov !== eo) begin
                n_miss++;
                $display("FAIL sweep_w%0d a=%h b=%h cin=%0d sub=%0d: lat=%0d s=%h co=%b ov=%b, want lat=%0d s=%h co=%b ov=%b",
                         w, ai, bi, ci, si, lat, s, co, ov, n_lat, 16'(es), ec, eo);
            end
            release_out();
        end
        sel = 0;
    endtask

    initial begin
        sel = 0;
        t_in_valid = 1'b0; t_out_ready = 1'b0; t_cin = 1'b0; t_sub = 1'b0;
        t_a = 16'h0000; t_b = 16'h0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_config_sweep(1, 4, 1);
        test_config_sweep(2, 8, 4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
